// File: rtl/mem_access_unit.sv
// Data-memory access controller: runs a req/ack bus cycle for loads/stores and stalls the datapath meanwhile.
// Optional feature: define MEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES cycles without ack.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        access, aligned, start, ack_hit, timeout;
  logic        bus_req_q, bus_we_q, misalign_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;

  assign access  = MemRead | MemWrite;
  assign aligned = (addr[1:0] == 2'b00);
  assign start   = (state_q == S_IDLE) && access && aligned;
  assign ack_hit = (state_q == S_REQ) && bus_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q;
  logic          bus_err_q;

  // Counter idles at zero outside REQ, so every REQ entry starts fresh.
  assign timeout = (state_q == S_REQ) && !bus_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (state_q != S_REQ) cnt_q <= '0;
      else if (!bus_ack)    cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE never re-samples the still-held access
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (bus_ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall = start || (state_q == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      misalign_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      bus_req_q  <= (state_d == S_REQ);
      misalign_q <= (state_q == S_IDLE) && access && !aligned;
      if (start) begin
        bus_addr_q <= {addr[31:2], 2'b00};
        bus_we_q   <= MemWrite;
        if (MemWrite) bus_wdata_q <= wdata;
      end
      if (ack_hit && !bus_we_q) rdata_q <= bus_rdata;
      else if (timeout)         rdata_q <= '0;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, bus_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;

  int nchk = 0, nerr = 0;
  logic [31:0] exp_rdata = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   bus_req,  0);
    check({tag, "_stall"}, stall,    0);
    check({tag, "_mis"},   misalign, 0);
    check({tag, "_err"},   bus_err,  0);
    check({tag, "_rdata"}, rdata,    exp_rdata);
  endtask

  // One memory instruction. w = REQ cycles before the ack cycle; w < 0 means never ack.
  task automatic run_acc(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int w, input logic [31:0] rdv);
    int st = 0, rq = 0, c = 0;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    @(negedge clk);
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd; bus_rdata = rdv;
    #1;
    if (a[1:0] != 2'b00) begin
      check("mis_stall", stall, 0);
      @(negedge clk); #1;
      MemRead = 0; MemWrite = 0;
      check("mis_pulse", misalign, 1);
      check("mis_req", bus_req, 0);
      @(negedge clk); #1;
      check("mis_clr", misalign, 0);
      check("mis_rdata", rdata, exp_rdata);
      return;
    end
    while (stall && c < 200) begin
      st++;
      if (bus_req) begin
        rq++;
        check("bus_addr", bus_addr, wa);
        check("bus_we", bus_we, 32'(wr));
        if (wr) check("bus_wdata", bus_wdata, wd);
      end
      bus_ack = (w >= 0) && (rq == w + 1);
      @(negedge clk); #1;
      c++;
    end
    bus_ack = 0;
    if (c >= 200) check("stall_bound", 32'(c), 0);
    if (w >= 0) begin
      if (!wr) exp_rdata = rdv;
      check("stall_cycles", 32'(st), 32'(w + 2));
      check("req_cycles", 32'(rq), 32'(w + 1));
      check("done_err", bus_err, 0);
    end else begin
      exp_rdata = '0;
      check("to_stall_cycles", 32'(st), 32'd16);
      check("to_req_cycles", 32'(rq), 32'd15);
      check("to_err", bus_err, 1);
    end
    check("done_req", bus_req, 0);
    check("done_rdata", rdata, exp_rdata);
    MemRead = 0; MemWrite = 0;
    @(negedge clk); #1;
    check_idle_outputs("post");
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_we", bus_we, 0);
    check_idle_outputs("rst");
    rst = 0;

    // Directed cases from the plan
    run_acc(1, 0, 32'h10, 32'h0, 0, 32'hCAFE_0001);
    run_acc(0, 1, 32'h20, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    run_acc(1, 0, 32'h13, 32'h0, 0, 32'h5555_5555);
    run_acc(1, 1, 32'h44, 32'hA5A5_0F0F, 1, 32'h7777_7777);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if (kind == 3) begin
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else a[1:0] = 2'b00;
      run_acc(kind != 1, kind == 1 || kind == 2, a, $urandom, $urandom_range(0, 4), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    run_acc(1, 0, 32'h80, 32'h0, -1, 32'h1111_2222);
    check("to_err_clr", bus_err, 0);
`endif

    // Hanging access, then reset while in REQ
    @(negedge clk);
    MemRead = 1; addr = 32'h100; bus_ack = 0;
`ifdef MEM_TIMEOUT_EN
    repeat (4) begin @(negedge clk); #1; check("hang_stall", stall, 1); end
`else
    repeat (40) begin @(negedge clk); #1; check("hang_stall", stall, 1); end
`endif
    check("hang_req", bus_req, 1);
    @(negedge clk);
    rst = 1; MemRead = 0;
    #1;
    exp_rdata = '0;
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_we", bus_we, 0);
    check("mid_rst_wdata", bus_wdata, 0);
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 0;
    run_acc(1, 0, 32'h204, 32'h0, 2, 32'hBEEF_0042);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
